// File: rtl/boom_anim_ctrl.sv
// Explosion sprite sequencer: latches the hit cell, steps animation frames
// during vertical blank and addresses the sprite ROM for the current scan pixel.
module boom_anim_ctrl #(
  parameter int unsigned FRAMES   = 4,
  parameter int unsigned HOLD     = 6,
  parameter int unsigned SPRITE_W = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_trigger,
  input  logic [9:0]                   i_boom_x,
  input  logic [9:0]                   i_boom_y,
  input  logic [9:0]                   i_pos_x,
  input  logic [9:0]                   i_pos_y,
  input  logic                         i_frame_start,
  output logic [$clog2(FRAMES)+7:0]    o_rom_addr,
  output logic                         o_pix_valid,
  output logic [$clog2(FRAMES)-1:0]    o_frame_idx,
  output logic                         o_busy,
  output logic                         o_done
);

  localparam int unsigned FB = $clog2(FRAMES);
  localparam int unsigned HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_PLAY  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e          state_q;
  logic [FB-1:0]   frame_idx_q;
  logic [HW-1:0]   hold_q;
  logic [9:0]      bx_q;
  logic [9:0]      by_q;
  logic            pix_valid_q;

  logic [9:0]      dx;
  logic [9:0]      dy;
  logic            in_region;

  // Wrap subtraction pushes pixels left of / above the cell far out of range
  assign dx        = i_pos_x - bx_q;
  assign dy        = i_pos_y - by_q;
  assign in_region = (dx < 10'(SPRITE_W)) && (dy < 10'(SPRITE_W));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      frame_idx_q <= '0;
      hold_q      <= '0;
      bx_q        <= '0;
      by_q        <= '0;
      pix_valid_q <= 1'b0;
    end else begin
      // One cycle behind the address, matching the ROM read latency
      pix_valid_q <= (state_q == S_PLAY) && in_region;
      case (state_q)
        S_IDLE: begin
          if (i_trigger) begin
            bx_q    <= i_boom_x;
            by_q    <= i_boom_y;
            state_q <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (i_frame_start) begin
            frame_idx_q <= '0;
            hold_q      <= '0;
            state_q     <= S_PLAY;
          end
        end
        S_PLAY: begin
          if (i_frame_start) begin
            if (hold_q == HW'(HOLD - 1)) begin
              hold_q <= '0;
              if (frame_idx_q == FB'(FRAMES - 1)) begin
                state_q <= S_DONE;
              end else begin
                frame_idx_q <= frame_idx_q + FB'(1);
              end
            end else begin
              hold_q <= hold_q + HW'(1);
            end
          end
        end
        S_DONE: begin
          frame_idx_q <= '0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_rom_addr  = {frame_idx_q, dy[3:0], dx[3:0]};
  assign o_pix_valid = pix_valid_q;
  assign o_frame_idx = frame_idx_q;
  assign o_busy      = (state_q == S_ARMED) || (state_q == S_PLAY);
  assign o_done      = (state_q == S_DONE);

endmodule

// File: tb/tb_boom_anim_ctrl.sv
// Bench for boom_anim_ctrl: directed test-plan sequences plus random traffic
// checked every cycle against a frame-pulse counting model.
module tb_boom_anim_ctrl;

  localparam int unsigned FRAMES = 4;
  localparam int unsigned HOLD   = 6;
  localparam int unsigned FB     = $clog2(FRAMES);

  logic          clk = 1'b0;
  logic          rst;
  logic          trig;
  logic [9:0]    boom_x, boom_y, pos_x, pos_y;
  logic          fs;
  logic [FB+7:0] rom_addr;
  logic          pix_valid;
  logic [FB-1:0] frame_idx;
  logic          busy;
  logic          done;

  int n_cmp = 0;
  int n_err = 0;

  // Model: an accepted trigger arms the effect; m_p counts frame_start pulses
  // seen since then. Pulse 1 starts playback, pulse FRAMES*HOLD+1 ends it.
  bit          m_armed;
  bit          m_done_now;
  int unsigned m_p;
  logic [9:0]  m_bx, m_by;
  bit          m_valid;

  always #5 clk = ~clk;

  boom_anim_ctrl #(.FRAMES(FRAMES), .HOLD(HOLD), .SPRITE_W(16)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_trigger     (trig),
    .i_boom_x      (boom_x),
    .i_boom_y      (boom_y),
    .i_pos_x       (pos_x),
    .i_pos_y       (pos_y),
    .i_frame_start (fs),
    .o_rom_addr    (rom_addr),
    .o_pix_valid   (pix_valid),
    .o_frame_idx   (frame_idx),
    .o_busy        (busy),
    .o_done        (done)
  );

  task automatic check_eq(input string tag, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, act, exp);
    end
  endtask

  // Advance one clock, update the model from pre-edge inputs, then check
  task automatic step();
    logic [9:0]  ex, ey;
    bit          playing;
    int unsigned exp_idx;
    int unsigned exp_addr;
    @(posedge clk);
    ex      = pos_x - m_bx;
    ey      = pos_y - m_by;
    playing = m_armed && (m_p >= 1);
    if (rst) begin
      m_armed = 0; m_done_now = 0; m_p = 0; m_bx = '0; m_by = '0; m_valid = 0;
    end else begin
      m_valid = playing && (ex < 10'd16) && (ey < 10'd16);
      if (m_done_now) begin
        m_done_now = 0;
      end else if (!m_armed) begin
        if (trig) begin
          m_armed = 1; m_p = 0; m_bx = boom_x; m_by = boom_y;
        end
      end else if (fs) begin
        m_p++;
        if (m_p - 1 == FRAMES * HOLD) begin
          m_armed = 0; m_done_now = 1; m_p = 0;
        end
      end
    end
    #1;
    if (m_armed && m_p >= 1) exp_idx = (m_p - 1) / HOLD;
    else if (m_done_now)     exp_idx = FRAMES - 1;
    else                     exp_idx = 0;
    ex       = pos_x - m_bx;
    ey       = pos_y - m_by;
    exp_addr = (exp_idx << 8) | (int'(ey[3:0]) << 4) | int'(ex[3:0]);
    check_eq("frame_idx", frame_idx, exp_idx);
    check_eq("busy", busy, m_armed);
    check_eq("done", done, m_done_now);
    check_eq("pix_valid", pix_valid, m_valid);
    check_eq("rom_addr", rom_addr, exp_addr);
  endtask

  task automatic drive(input bit r, input bit t, input int unsigned bx, input int unsigned by,
                       input int unsigned px, input int unsigned py, input bit f);
    rst = r; trig = t; fs = f;
    boom_x = 10'(bx); boom_y = 10'(by); pos_x = 10'(px); pos_y = 10'(py);
    step();
  endtask

  // n frame_start pulses, each followed by gap cycles scanning near the cell
  task automatic pulses(input int n, input int gap, input int unsigned cx, input int unsigned cy);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, cx, cy, 1);
      for (int j = 0; j < gap; j++)
        drive(0, 0, 0, 0, cx + $urandom_range(0, 19) - 2, cy + $urandom_range(0, 19) - 2, 0);
    end
  endtask

  initial begin
    m_armed = 0; m_done_now = 0; m_p = 0; m_bx = '0; m_by = '0; m_valid = 0;
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);

    // Basic hit at (100,200) and region corners
    drive(0, 1, 100, 200, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 100, 200, 0);
    drive(0, 0, 0, 0, 115, 215, 0);
    drive(0, 0, 0, 0, 116, 200, 0);
    drive(0, 0, 0, 0, 99, 200, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    // Full playback with an ignored re-trigger mid-way
    pulses(10, 3, 100, 200);
    drive(0, 1, 300, 300, 305, 305, 0);
    drive(0, 0, 0, 0, 100, 200, 0);
    pulses(14, 3, 100, 200);
    drive(0, 0, 0, 0, 100, 200, 0);
    drive(0, 0, 0, 0, 100, 200, 0);
    drive(0, 0, 0, 0, 100, 200, 0);

    // Trigger and frame_start in the same idle cycle
    drive(0, 1, 100, 200, 100, 200, 1);
    drive(0, 0, 0, 0, 100, 200, 0);
    pulses(13, 2, 100, 200);
    // Abort with reset at frame_idx 2
    drive(1, 0, 0, 0, 100, 200, 0);
    drive(0, 0, 0, 0, 100, 200, 0);
    drive(0, 0, 0, 0, 100, 200, 1);

    // Cell at origin: left-of-cell pixel wraps outside
    drive(0, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1023, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1023, 0);
    pulses(25, 2, 0, 0);

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      int unsigned bx, by, px, py;
      bx = $urandom_range(0, 1023);
      by = $urandom_range(0, 1023);
      if ($urandom_range(0, 3) == 0) begin
        px = $urandom_range(0, 1023);
        py = $urandom_range(0, 1023);
      end else begin
        px = m_bx + $urandom_range(0, 19) - 2;
        py = m_by + $urandom_range(0, 19) - 2;
      end
      drive($urandom_range(0, 599) == 0, $urandom_range(0, 39) == 0, bx, by, px, py,
            $urandom_range(0, 5) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/boom_anim_ctrl.md
Name: boom_anim_ctrl

Overview:
Sequences the multi-frame explosion sprite ROM (FRAMES x 16x16 texels, 24-bit colour, 1-cycle synchronous read) when a bomb is hit. Latches the 16x16 screen cell where the explosion is drawn. Steps the frame index on video-frame boundaries and generates the ROM address for the current scan pixel. Emits a pixel-valid flag aligned with ROM output, so the VGA mixer can overlay explosion pixels without tearing.

Parameters:
FRAMES, 4, number of animation frames in ROM; power of two, >= 2; FB = $clog2(FRAMES)
HOLD, 6, video frames each animation frame is displayed; >= 1
SPRITE_W, 16, sprite edge in pixels; fixed at 16 (4-bit texel coords)

Ports:
i_clk  in  1  pixel clock
i_rst  in  1  synchronous reset, active-high
i_trigger  in  1  1-cycle pulse: bomb hit, start explosion
i_boom_x  in  10  sprite cell left edge, sampled with i_trigger
i_boom_y  in  10  sprite cell top edge, sampled with i_trigger
i_pos_x  in  10  current scan pixel x
i_pos_y  in  10  current scan pixel y
i_frame_start  in  1  1-cycle pulse at start of vertical blank
o_rom_addr  out  FB+8  {frame_idx, dy[3:0], dx[3:0]} to ROM address
o_pix_valid  out  1  ROM q this cycle is an explosion pixel
o_frame_idx  out  FB  current animation frame
o_busy  out  1  high in ARMED or PLAY
o_done  out  1  1-cycle pulse at end of animation

Behaviour:
- Reset: state=IDLE, frame_idx=0, hold_cnt=0, latched x/y=0, o_pix_valid=0, o_done=0, o_busy=0. Reset asserted mid-animation aborts it. o_pix_valid is 0 the cycle after reset is sampled. No o_done is emitted.
- States:
  - IDLE:
    - On i_trigger: latch bx<=i_boom_x, by<=i_boom_y, then go to ARMED.
    - An i_frame_start in the same cycle is not consumed; playback starts at the following i_frame_start.
  - ARMED: on i_frame_start go to PLAY with frame_idx=0 and hold_cnt=0.
  - PLAY: on each i_frame_start:
    - If hold_cnt==HOLD-1 and frame_idx==FRAMES-1: go to DONE.
    - Else if hold_cnt==HOLD-1: frame_idx++, hold_cnt<=0.
    - Else: hold_cnt++.
  - DONE: o_done=1 for exactly this cycle, frame_idx<=0, then go to IDLE.
- i_trigger in ARMED, PLAY or DONE is ignored; bx/by are unchanged.
- Region test: dx = i_pos_x - bx and dy = i_pos_y - by, as 10-bit unsigned wrap subtraction. in_region = (dx < 16) && (dy < 16). Pixels left of or above the cell wrap to large values and are therefore outside.
- o_rom_addr is combinational: {frame_idx, dy[3:0], dx[3:0]}. It is driven every cycle regardless of in_region.
- o_pix_valid is registered: o_pix_valid <= (state==PLAY) && in_region.
  - This gives one cycle of latency, matching the ROM read, so o_pix_valid qualifies q for the address presented the previous cycle.
- A frame_idx change takes effect only at i_frame_start, i.e. during blanking, so there is no mid-frame tearing.
- o_busy = (state==ARMED || state==PLAY). It is combinational from state.
- Total display time = FRAMES*HOLD video frames, counted from the first i_frame_start after the trigger.

Test Plan:
- Reset, then trigger with bx=100, by=200. Next i_frame_start enters PLAY. Pixel (100,200) gives o_rom_addr=0x000 and o_pix_valid=1 one cycle later. Pixel (115,215) gives addr=0x0FF and valid=1. Pixels (116,200) and (99,200) give valid=0.
- FRAMES=4, HOLD=6: count frame_start pulses after PLAY entry. frame_idx steps 0->1->2->3 after the 6th, 12th and 18th pulses. The 24th pulse gives o_done for 1 cycle, then IDLE. o_busy=0 and valid=0 afterwards.
- i_trigger and i_frame_start in the same IDLE cycle: state goes to ARMED. PLAY starts only at the next frame_start.
- Second i_trigger during PLAY with new coordinates (300,300): bx/by stay at (100,200). The frame sequence is unaffected.
- Assert i_rst during PLAY at frame_idx=2: next cycle gives IDLE, frame_idx=0, valid=0, no o_done pulse.
- bx=0, by=0, pixel (1023,0): dx wraps to 1023, so valid=0. Pixel (0,0) gives addr[7:0]=0x00 and valid=1.
